// File: rtl/fc_sequencer.sv
// Drives one fc layer pass: streams N_IN operands from a source memory into the
// layer and writes its indexed results back, forward or backward.
module fc_sequencer #(
    parameter int IN_SIZE  = 1024,
    parameter int OUT_SIZE = 10,
    parameter int IDX_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] src_addr,
    input  logic [31:0]      src_data,
    output logic             fc_forward,
    output logic             fc_load_weights,
    output logic [31:0]      fc_input,
    output logic [IDX_W-1:0] fc_in_idx,
    input  logic             fc_in_rdy,
    output logic             fc_out_rdy,
    input  logic             fc_out_valid,
    input  logic [31:0]      fc_output,
    input  logic [IDX_W-1:0] fc_out_idx,
    output logic             res_we,
    output logic [IDX_W-1:0] res_addr,
    output logic [31:0]      res_data
);

    // One extra bit so a counter can hold the full vector length.
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_fwd;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_out_rdy;
    logic             r_res_we;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_cnt;
    logic [IDX_W-1:0] r_src_addr;
    logic [IDX_W-1:0] r_fc_in_idx;
    logic [IDX_W-1:0] r_res_addr;
    logic [31:0]      r_fc_input;
    logic [31:0]      r_res_data;

    logic [CNT_W-1:0] w_n_in;
    logic [CNT_W-1:0] w_n_out;
    logic             w_take;
    logic             w_res_ok;

    assign w_n_in   = r_fwd ? CNT_W'(IN_SIZE)  : CNT_W'(OUT_SIZE);
    assign w_n_out  = r_fwd ? CNT_W'(OUT_SIZE) : CNT_W'(IN_SIZE);
    assign w_take   = fc_out_valid && r_out_rdy;
    assign w_res_ok = {1'b0, fc_out_idx} < w_n_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fwd       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_rdy   <= 1'b0;
            r_res_we    <= 1'b0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_src_addr  <= '0;
            r_fc_in_idx <= '0;
            r_res_addr  <= '0;
            r_fc_input  <= '0;
            r_res_data  <= '0;
        end else begin
            r_res_we <= 1'b0;
            if (abort) begin
                r_state    <= S_IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_out_rdy  <= 1'b0;
                r_in_cnt   <= '0;
                r_out_cnt  <= '0;
                r_src_addr <= '0;
            end else begin
                // Result path runs independently of the feed path below.
                if (w_take) begin
                    if (w_res_ok) begin
                        r_res_we   <= 1'b1;
                        r_res_addr <= fc_out_idx;
                        r_res_data <= fc_output;
                        r_out_cnt  <= r_out_cnt + CNT_W'(1);
                    end else begin
                        r_err <= 1'b1;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_fwd      <= ~mode;
                            r_in_cnt   <= '0;
                            r_out_cnt  <= '0;
                            r_err      <= 1'b0;
                            r_src_addr <= '0;
                            r_busy     <= 1'b1;
                            r_out_rdy  <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_fc_input  <= src_data;
                        r_fc_in_idx <= r_in_cnt[IDX_W-1:0];
                        r_state     <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (r_in_cnt < w_n_in) begin
                            if (fc_in_rdy) begin
                                r_in_cnt <= r_in_cnt + CNT_W'(1);
                                if (r_in_cnt < w_n_in - CNT_W'(1)) begin
                                    r_src_addr <= r_in_cnt[IDX_W-1:0] + IDX_W'(1);
                                    r_state    <= S_FETCH;
                                end
                            end
                        end else if (r_out_cnt >= w_n_out) begin
                            // Greater-or-equal so duplicate results cannot stall completion.
                            r_done    <= 1'b1;
                            r_out_rdy <= 1'b0;
                            r_state   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign src_addr        = r_src_addr;
    assign fc_forward      = r_fwd;
    assign fc_load_weights = 1'b0;
    assign fc_input        = r_fc_input;
    assign fc_in_idx       = r_fc_in_idx;
    assign fc_out_rdy      = r_out_rdy;
    assign res_we          = r_res_we;
    assign res_addr        = r_res_addr;
    assign res_data        = r_res_data;

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: a pass-level model checked every cycle plus directed
// scenarios with hand-computed timing and counts.
module tb_fc_sequencer;

    localparam int IN_SIZE  = 1024;
    localparam int OUT_SIZE = 10;
    localparam int IDX_W    = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, err;
    logic [IDX_W-1:0] src_addr;
    logic [31:0]      src_data;
    logic             fc_forward, fc_load_weights;
    logic [31:0]      fc_input;
    logic [IDX_W-1:0] fc_in_idx;
    logic             fc_in_rdy = 1'b0;
    logic             fc_out_rdy;
    logic             fc_out_valid = 1'b0;
    logic [31:0]      fc_output = '0;
    logic [IDX_W-1:0] fc_out_idx = '0;
    logic             res_we;
    logic [IDX_W-1:0] res_addr;
    logic [31:0]      res_data;

    logic [31:0] mem_base = 32'h0001_0000;
    logic [31:0] mem_step = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_cnt  = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    // Pass-level model state
    bit          m_act, m_done, m_gap, m_err, m_we, m_fwd;
    int          m_nin, m_nout, m_fed, m_got, m_idx, m_waddr;
    logic [31:0] m_data, m_wdata;

    assign src_data = mem_base + mem_step * {{(32-IDX_W){1'b0}}, src_addr};

    fc_sequencer #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .err(err), .src_addr(src_addr), .src_data(src_data),
        .fc_forward(fc_forward), .fc_load_weights(fc_load_weights),
        .fc_input(fc_input), .fc_in_idx(fc_in_idx), .fc_in_rdy(fc_in_rdy),
        .fc_out_rdy(fc_out_rdy), .fc_out_valid(fc_out_valid), .fc_output(fc_output),
        .fc_out_idx(fc_out_idx), .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_val(input int a);
        return mem_base + mem_step * 32'(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare at negedge, then advance the model with the inputs the DUT sees at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_res_we", 32'(res_we), 32'd0);
            check("rst_out_rdy", 32'(fc_out_rdy), 32'd0);
            check("rst_fwd", 32'(fc_forward), 32'd0);
            check("rst_src_addr", 32'(src_addr), 32'd0);
            check("rst_fc_input", fc_input, 32'd0);
            m_act = 0; m_done = 0; m_gap = 0; m_err = 0; m_we = 0; m_fwd = 0;
            m_fed = 0; m_got = 0;
        end else begin
            bit fin;
            check("m_busy", 32'(busy), 32'(m_act || m_done));
            check("m_done", 32'(done), 32'(m_done));
            check("m_err", 32'(err), 32'(m_err));
            check("m_out_rdy", 32'(fc_out_rdy), 32'(m_act));
            check("m_fwd", 32'(fc_forward), 32'(m_fwd));
            check("m_load_w", 32'(fc_load_weights), 32'd0);
            check("m_res_we", 32'(res_we), 32'(m_we));
            if (m_we) begin
                check("m_res_addr", 32'(res_addr), 32'(m_waddr));
                check("m_res_data", res_data, m_wdata);
            end
            if (m_act && m_gap) check("m_src_addr", 32'(src_addr), 32'(m_fed));
            if (m_act && !m_gap) begin
                check("m_in_idx", 32'(fc_in_idx), 32'(m_idx));
                check("m_in_data", fc_input, m_data);
            end
            if (res_we) we_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            fin  = (m_fed == m_nin) && (m_got >= m_nout);
            m_we = 0;
            if (abort) begin
                m_act = 0; m_done = 0; m_gap = 0; m_fed = 0; m_got = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (!m_act) begin
                if (start) begin
                    m_act = 1; m_gap = 1; m_err = 0; m_fwd = !mode;
                    m_nin  = mode ? OUT_SIZE : IN_SIZE;
                    m_nout = mode ? IN_SIZE : OUT_SIZE;
                    m_fed = 0; m_got = 0;
                end
            end else begin
                if (fc_out_valid) begin
                    if (int'(fc_out_idx) < m_nout) begin
                        m_we = 1; m_waddr = int'(fc_out_idx); m_wdata = fc_output; m_got++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (m_gap) begin
                    m_gap = 0; m_idx = m_fed; m_data = mem_val(m_fed);
                end else if (m_fed < m_nin) begin
                    if (fc_in_rdy) begin
                        m_fed++;
                        m_gap = (m_fed < m_nin);
                    end
                end else if (fin) begin
                    m_act = 0; m_done = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int idx, input logic [31:0] d);
        fc_out_valid = 1'b1;
        fc_out_idx   = IDX_W'(idx);
        fc_output    = d;
        tick();
        fc_out_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != d0) return;
            tick();
        end
        check("done_timeout", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int t0, d0, w0;
        repeat (3) tick();
        check("init_busy", 32'(busy), 32'd0);
        check("init_res_addr", 32'(res_addr), 32'd0);
        check("init_fc_in_idx", 32'(fc_in_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Results offered while idle are dropped
        w0 = we_cnt;
        send(2, 32'h1234_5678);
        repeat (2) tick();
        check("idle_no_we", 32'(we_cnt - w0), 32'd0);

        // Forward pass
        mem_base = 32'h0001_0000; mem_step = 32'h0; fc_in_rdy = 1'b1;
        d0 = done_cnt; w0 = we_cnt;
        start = 1'b1; mode = 1'b0; t0 = cyc; tick(); start = 1'b0;
        check("fwd_forward", 32'(fc_forward), 32'd1);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) send(i, 32'(i) * 32'h1_0000 + 32'd7);
        wait_done(3000, d0);
        check("fwd_done_cyc", 32'(done_cyc - t0), 32'd2050);
        repeat (3) tick();
        check("fwd_we_count", 32'(we_cnt - w0), 32'd10);
        check("fwd_done_count", 32'(done_cnt - d0), 32'd1);
        check("fwd_busy_after", 32'(busy), 32'd0);
        check("fwd_last_idx", 32'(fc_in_idx), 32'd1023);

        // Backward pass
        mem_step = 32'h100;
        d0 = done_cnt; w0 = we_cnt;
        start = 1'b1; mode = 1'b1; t0 = cyc; tick(); start = 1'b0;
        check("bwd_forward", 32'(fc_forward), 32'd0);
        repeat (2) tick();
        for (int j = 0; j < 1024; j++) send(j, 32'(j) * 32'h1_0000);
        wait_done(100, d0);
        check("bwd_done_cyc", 32'(done_cyc - t0), 32'd1028);
        repeat (3) tick();
        check("bwd_we_count", 32'(we_cnt - w0), 32'd1024);
        check("bwd_done_count", 32'(done_cnt - d0), 32'd1);
        check("bwd_last_idx", 32'(fc_in_idx), 32'd9);

        // Backpressure at index 3
        mem_step = 32'h10;
        d0 = done_cnt; w0 = we_cnt;
        start = 1'b1; mode = 1'b0; t0 = cyc; tick(); start = 1'b0;
        repeat (7) tick();
        fc_in_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_idx", 32'(fc_in_idx), 32'd3);
            check("bp_data", fc_input, 32'h0001_0030);
            tick();
        end
        fc_in_rdy = 1'b1;
        check("bp_idx_release", 32'(fc_in_idx), 32'd3);
        for (int i = 0; i < 10; i++) send(i, 32'hA000 + 32'(i));
        wait_done(3000, d0);
        check("bp_done_cyc", 32'(done_cyc - t0), 32'd2055);
        repeat (3) tick();
        check("bp_we_count", 32'(we_cnt - w0), 32'd10);

        // Out-of-range result index
        mem_step = 32'h0;
        d0 = done_cnt; w0 = we_cnt;
        start = 1'b1; mode = 1'b0; t0 = cyc; tick(); start = 1'b0;
        repeat (2) tick();
        send(12, 32'hDEAD_BEEF);
        check("bad_err_set", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) send(i, 32'h5000 + 32'(i));
        wait_done(3000, d0);
        check("bad_done_cyc", 32'(done_cyc - t0), 32'd2050);
        repeat (3) tick();
        check("bad_we_count", 32'(we_cnt - w0), 32'd10);
        check("bad_err_sticky", 32'(err), 32'd1);

        // Abort together with start at in_cnt=500
        d0 = done_cnt;
        start = 1'b1; mode = 1'b0; tick(); start = 1'b0;
        check("abt_err_cleared", 32'(err), 32'd0);
        repeat (1000) tick();
        check("abt_src_addr", 32'(src_addr), 32'd500);
        abort = 1'b1; start = 1'b1;
        fc_out_valid = 1'b1; fc_out_idx = IDX_W'(1); fc_output = 32'h77;
        w0 = we_cnt;
        tick();
        abort = 1'b0; start = 1'b0; fc_out_valid = 1'b0;
        check("abt_busy", 32'(busy), 32'd0);
        check("abt_out_rdy", 32'(fc_out_rdy), 32'd0);
        tick();
        check("abt_no_we", 32'(we_cnt - w0), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("abt_restart_busy", 32'(busy), 32'd1);
        check("abt_restart_addr", 32'(src_addr), 32'd0);
        tick();
        check("abt_restart_idx", 32'(fc_in_idx), 32'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        repeat (2) tick();
        check("abt_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset mid-FETCH
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_rdy", 32'(fc_out_rdy), 32'd0);
        check("arst_fwd", 32'(fc_forward), 32'd0);
        check("arst_src_addr", 32'(src_addr), 32'd0);
        check("arst_fc_input", fc_input, 32'd0);
        check("arst_res_addr", 32'(res_addr), 32'd0);
        check("arst_res_data", res_data, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
